// File: rtl/mul_pkg.sv
// Shared types and partial-product tables for the 16x16 sequential sign-magnitude multiplier.
package mul_pkg;

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;

   typedef logic [1:0] pp_idx_t;

   localparam int NUM_PP = 4;

   // Bit k set means partial product k takes the high byte of that operand.
   localparam logic [NUM_PP-1:0] PP_A_HI = 4'b1010;
   localparam logic [NUM_PP-1:0] PP_B_HI = 4'b1100;

   function automatic logic [4:0] pp_shift(input pp_idx_t k);
      logic [4:0] sh;
      case (k)
         2'd0:    sh = 5'd0;
         2'd1:    sh = 5'd8;
         2'd2:    sh = 5'd8;
         default: sh = 5'd16;
      endcase
      return sh;
   endfunction

   // Returns {a_byte, b_byte} feeding partial product k.
   function automatic logic [15:0] pp_bytes(input pp_idx_t k, input logic [15:0] a,
                                             input logic [15:0] b);
      logic [7:0] ab;
      logic [7:0] bb;
      ab = PP_A_HI[k] ? a[15:8] : a[7:0];
      bb = PP_B_HI[k] ? b[15:8] : b[7:0];
      return {ab, bb};
   endfunction

endpackage

// File: rtl/mul16_pp_acc.sv
// 32-bit shift-add accumulator: clears at operation start, adds each shifted partial product.
module mul16_pp_acc
   import mul_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr_i,
   input  logic        en_i,
   input  pp_idx_t     sel_i,
   input  logic [15:0] mul_p_i,
   output logic [31:0] acc_o
);

   logic [31:0] acc_q;
   logic [31:0] acc_d;

   always_comb begin
      acc_d = acc_q;
      if (clr_i) begin
         acc_d = '0;
      end else if (en_i) begin
         acc_d = acc_q + ({16'd0, mul_p_i} << pp_shift(sel_i));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign acc_o = acc_q;

endmodule

// File: rtl/mul16_seq_ctrl.sv
// Sequencer building a 16x16 sign-magnitude product from four passes through one external
// 8x8 unsigned multiplier, with optional skipping of partial products that have a zero byte.
module mul16_seq_ctrl
   import mul_pkg::*;
#(
   parameter int MUL_LAT   = 1,
   parameter bit SKIP_ZERO = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        asign,
   input  logic        bsign,
   output logic        mul_en,
   output logic [7:0]  mul_a,
   output logic [7:0]  mul_b,
   input  logic [15:0] mul_p,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] m,
   output logic        sign,
   output logic        busy
);

   localparam int CNT_W = (MUL_LAT > 0) ? $clog2(MUL_LAT + 1) : 1;
   localparam logic [CNT_W-1:0] LAT_C = CNT_W'(MUL_LAT);

   state_e           state_q, state_d;
   pp_idx_t          k_q, k_d;
   logic             fin_q, fin_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sign_q, sign_d;
   logic [15:0]      a_q, b_q;
   logic             acc_clr;
   logic             pp_found;
   logic             pp_done;
   pp_idx_t          pp_k;
   logic [15:0]      pp_ab;
   logic [31:0]      acc;

   // Lowest-numbered pending partial product at or after k_q; skipped ones cost no cycles.
   always_comb begin
      logic [15:0] cand;
      pp_found = 1'b0;
      pp_k     = k_q;
      cand     = '0;
      for (int i = NUM_PP - 1; i >= 0; i--) begin
         cand = pp_bytes(pp_idx_t'(i), a_q, b_q);
         if ((state_q == ST_RUN) && !fin_q && (i >= int'(k_q)) &&
             (!SKIP_ZERO || ((cand[15:8] != 8'd0) && (cand[7:0] != 8'd0)))) begin
            pp_found = 1'b1;
            pp_k     = pp_idx_t'(i);
         end
      end
   end

   assign pp_ab   = pp_bytes(pp_k, a_q, b_q);
   assign pp_done = pp_found && (cnt_q == LAT_C);

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      fin_d   = fin_q;
      cnt_d   = cnt_q;
      sign_d  = sign_q;
      acc_clr = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               state_d = ST_RUN;
               k_d     = '0;
               fin_d   = 1'b0;
               cnt_d   = '0;
               sign_d  = asign ^ bsign;
               acc_clr = 1'b1;
            end
         end
         ST_RUN: begin
            if (!pp_found) begin
               state_d = ST_DONE;
            end else if (pp_done) begin
               cnt_d = '0;
               if (pp_k == 2'd3) begin
                  fin_d = 1'b1;
               end else begin
                  k_d = pp_idx_t'(pp_k + 2'd1);
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         k_q     <= '0;
         fin_q   <= 1'b0;
         cnt_q   <= '0;
         sign_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         fin_q   <= fin_d;
         cnt_q   <= cnt_d;
         sign_q  <= sign_d;
      end
   end

   // Operand magnitudes are pure data; they are only read while RUN is active.
   always_ff @(posedge clk) begin
      if ((state_q == ST_IDLE) && in_valid) begin
         a_q <= a;
         b_q <= b;
      end
   end

   mul16_pp_acc u_acc (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr_i   (acc_clr),
      .en_i    (pp_done),
      .sel_i   (pp_k),
      .mul_p_i (mul_p),
      .acc_o   (acc)
   );

   assign in_ready  = (state_q == ST_IDLE);
   assign busy      = (state_q != ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign m         = out_valid ? acc : 32'd0;
   assign sign      = out_valid ? sign_q : 1'b0;
   assign mul_en    = pp_found;
   assign mul_a     = pp_found ? pp_ab[15:8] : 8'd0;
   assign mul_b     = pp_found ? pp_ab[7:0] : 8'd0;

endmodule
